count_cmd_sequencer: RTL

Command-driven controller that sits directly upstream of the 3-bit up/down counter and generates its `load`, `count_up`, `counter_on` and `Data_in` controls. It accepts LOAD / UP / DOWN / HOLD commands over a valid/ready handshake and expands each one into a cycle-exact control sequence. It keeps a shadow copy of the counter value, so system logic can read the count and detect completion without tapping the counter.

---
 rtl/count_cmd_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/count_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// count_cmd_sequencer
//
// Turns LOAD / UP / DOWN / HOLD commands into the load / count_up /
// counter_on / Data_in controls of a WIDTH-bit up/down counter. It also keeps
// a shadow copy of the counter value.
//
// Optional feature macro: CMD_SEQ_WRAP_GUARD_EN
//   When defined, a STEP command that would wrap the counter stops at the
//   limit. That cycle has done=1 and no count, and the sticky sat_flag is set.
//   When undefined, the counter wraps freely and sat_flag is tied to 0.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (accept when both are 1)
//   cmd_op              00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//   cmd_arg             LOAD value (low WIDTH bits) or cycle count n
//   load, count_up,
//   counter_on, Data_in controls to the downstream counter
//   busy                command in progress
//   done                pulse in the last active cycle of a command
//   shadow_count        mirror of the counter's Count
//   sat_flag            sticky wrap-guard indication
// ---------------------------------------------------------------------------
module count_cmd_sequencer #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    output logic              load,
    output logic              count_up,
    output logic              counter_on,
    output logic [WIDTH-1:0]  Data_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  shadow_count,
    output logic              sat_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_STEP = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              up_q, up_d;
    logic [WIDTH-1:0]  val_q, val_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
`ifdef CMD_SEQ_WRAP_GUARD_EN
    logic              sat_q, sat_d;
`endif

    op_t               op_in;
    logic              stop;
    logic              ctl_load, ctl_on, ctl_up, ctl_done;
    logic [WIDTH-1:0]  ctl_data;

    assign op_in = op_t'(cmd_op);

    // Control decode from registered state only. Reset gates the visible
    // outputs so that nothing is driven during reset.
    always_comb begin
        stop     = 1'b0;
        ctl_load = 1'b0;
        ctl_on   = 1'b0;
        ctl_up   = 1'b0;
        ctl_done = 1'b0;
        ctl_data = '0;
`ifdef CMD_SEQ_WRAP_GUARD_EN
        // Stop at the limit instead of letting the counter wrap.
        if (state_q == S_STEP) begin
            stop = up_q ? (shadow_q == '1) : (shadow_q == '0);
        end
`endif
        case (state_q)
            S_LOAD: begin
                ctl_load = 1'b1;
                ctl_data = val_q;
                ctl_done = 1'b1;
            end
            S_STEP: begin
                ctl_on   = ~stop;
                ctl_up   = up_q;
                ctl_done = stop | (rem_q == STEP_W'(1));
            end
            S_HOLD: begin
                ctl_done = (rem_q == STEP_W'(1));
            end
            default: ;
        endcase
    end

    assign cmd_ready    = ~reset & (state_q == S_IDLE);
    assign busy         = ~reset & (state_q != S_IDLE);
    assign load         = ~reset & ctl_load;
    assign counter_on   = ~reset & ctl_on;
    assign count_up     = ~reset & ctl_up;
    assign done         = ~reset & ctl_done;
    assign Data_in      = reset ? '0 : ctl_data;
    assign shadow_count = shadow_q;
`ifdef CMD_SEQ_WRAP_GUARD_EN
    assign sat_flag     = sat_q;
`else
    assign sat_flag     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        up_d     = up_q;
        val_d    = val_q;
        shadow_d = shadow_q;
`ifdef CMD_SEQ_WRAP_GUARD_EN
        sat_d    = sat_q | stop;
`endif

        // Shadow follows the counter on the same edge that applies the control.
        if (ctl_load) begin
            shadow_d = val_q;
        end else if (ctl_on) begin
            shadow_d = ctl_up ? shadow_q + WIDTH'(1) : shadow_q - WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    up_d  = (op_in == OP_UP);
                    val_d = cmd_arg[WIDTH-1:0];
                    if (op_in == OP_LOAD) begin
                        state_d = S_LOAD;
                        rem_d   = '0;
                    end else if (cmd_arg == '0) begin
                        // A zero-length command still takes one cycle.
                        state_d = S_HOLD;
                        rem_d   = STEP_W'(1);
                    end else if (op_in == OP_HOLD) begin
                        state_d = S_HOLD;
                        rem_d   = cmd_arg;
                    end else begin
                        state_d = S_STEP;
                        rem_d   = cmd_arg;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                // A guard stop can finish with steps left, so clear rem.
                rem_d = rem_q - STEP_W'(1);
                if (ctl_done) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            up_q     <= 1'b0;
            val_q    <= '0;
            shadow_q <= '0;
`ifdef CMD_SEQ_WRAP_GUARD_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            up_q     <= up_d;
            val_q    <= val_d;
            shadow_q <= shadow_d;
`ifdef CMD_SEQ_WRAP_GUARD_EN
            sat_q    <= sat_d;
`endif
        end
    end

endmodule
